// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file with pending-write scoreboard.
package regfile_pkg;

  // Default reset contents of entries 1..DEPTH-1
  localparam logic [31:0] DEF_RESET_VAL = 32'h1000_0000;

  // Error classification, mainly for the bench when decoding the sticky flags
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_OVF,
    ERR_UNALLOC
  } err_code_e;

  // Register index width
  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

  // Width of a pending-write counter able to hold 0..max_out
  function automatic int calc_cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/regfile_sb_cnt.sv
// One scoreboard counter: saturating up/down count of outstanding writes to one register.
// inc and dec together cancel; ovf/unalloc are single-cycle error pulses.
module regfile_sb_cnt #(
  parameter int CNT_W   = 2,
  parameter int MAX_OUT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             unalloc
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: hold at MAX_OUT on over-allocation, hold at 0 on unallocated write
  always_comb begin
    cnt_d   = cnt_q;
    ovf     = 1'b0;
    unalloc = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == MAX_C) ovf = 1'b1;
      else                cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) unalloc = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised multi-read-port register file with per-register pending-write scoreboard.
// Entry 0 reads as zero and has no storage. Reads bypass a same-cycle write.
// Optional even-parity protection per entry when REGFILE_PARITY_EN is defined (adds rd_perr).
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 32,
  parameter int                NUM_RD    = 2,
  parameter int                MAX_OUT   = 3,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(DEF_RESET_VAL),
  parameter int                ZERO_IDX  = 4,
  localparam int               AW        = calc_aw(DEPTH),
  localparam int               CNT_W     = calc_cnt_w(MAX_OUT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     alloc_en,
  input  logic [AW-1:0]            alloc_addr,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  output logic                     err_ovf,
  output logic                     err_unalloc
`ifdef REGFILE_PARITY_EN
  ,
  output logic [NUM_RD-1:0]        rd_perr
`endif
);

  logic [DATA_W-1:0] mem_q [DEPTH-1:1];
  logic [DATA_W-1:0] mem_d [DEPTH-1:1];
  logic [DATA_W-1:0] view  [DEPTH];

  logic [DEPTH-1:1][CNT_W-1:0] cnt_e;
  logic [DEPTH-1:0][CNT_W-1:0] cnt_all;
  logic [DEPTH-1:1]            ovf_p, unalloc_p;

  logic err_ovf_q, err_ovf_d;
  logic err_unalloc_q, err_unalloc_d;

  // Next storage contents: write lands on the addressed entry (index 0 has no entry)
  always_comb begin
    for (int i = 1; i < DEPTH; i++)
      mem_d[i] = (wr_en && wr_addr == AW'(i)) ? wr_data : mem_q[i];
  end

  // Storage flops; ZERO_IDX resets to 0, all others to RESET_VAL
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < DEPTH; i++)
        mem_q[i] <= (i == ZERO_IDX) ? '0 : RESET_VAL;
    end else begin
      for (int i = 1; i < DEPTH; i++)
        mem_q[i] <= mem_d[i];
    end
  end

  // Full-depth read view with a constant-zero entry 0
  always_comb begin
    view[0] = '0;
    for (int i = 1; i < DEPTH; i++) view[i] = mem_q[i];
  end

  // One scoreboard counter per real entry
  for (genvar g = 1; g < DEPTH; g++) begin : g_sb
    logic inc, dec;
    assign inc = alloc_en && (alloc_addr == AW'(g));
    assign dec = wr_en && (wr_addr == AW'(g));
    regfile_sb_cnt #(.CNT_W(CNT_W), .MAX_OUT(MAX_OUT)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc),
      .dec     (dec),
      .cnt     (cnt_e[g]),
      .ovf     (ovf_p[g]),
      .unalloc (unalloc_p[g])
    );
  end

  // Full-depth count view with a constant-zero entry 0
  always_comb begin
    cnt_all[0] = '0;
    for (int i = 1; i < DEPTH; i++) cnt_all[i] = cnt_e[i];
  end

  // Sticky error flags, cleared only by reset
  always_comb begin
    err_ovf_d     = err_ovf_q | (|ovf_p);
    err_unalloc_d = err_unalloc_q | (|unalloc_p);
  end

  // Error flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_ovf_q     <= 1'b0;
      err_unalloc_q <= 1'b0;
    end else begin
      err_ovf_q     <= err_ovf_d;
      err_unalloc_q <= err_unalloc_d;
    end
  end

  assign err_ovf     = err_ovf_q;
  assign err_unalloc = err_unalloc_q;

`ifdef REGFILE_PARITY_EN
  logic [DEPTH-1:1] par_q, par_d;
  logic [DEPTH-1:0] par_all;

  // Parity bit is captured with the data and otherwise held, so a corrupted bit persists
  always_comb begin
    for (int i = 1; i < DEPTH; i++)
      par_d[i] = (wr_en && wr_addr == AW'(i)) ? ^wr_data : par_q[i];
  end

  // Parity flops, reset consistent with the reset contents
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < DEPTH; i++)
        par_q[i] <= (i == ZERO_IDX) ? 1'b0 : ^RESET_VAL;
    end else begin
      par_q <= par_d;
    end
  end

  // Full-depth parity view; entry 0 is always consistent
  always_comb begin
    par_all[0] = 1'b0;
    for (int i = 1; i < DEPTH; i++) par_all[i] = par_q[i];
  end
`endif

  // Read ports: zero for index 0, write-first bypass, pending from effective count
  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
`ifdef REGFILE_PARITY_EN
    rd_perr    = '0;
`endif
    for (int p = 0; p < NUM_RD; p++) begin
      logic [AW-1:0]    a;
      logic             byp;
      logic [CNT_W-1:0] c;
      a   = rd_addr[p*AW +: AW];
      byp = wr_en && (wr_addr == a) && (a != '0);
      c   = cnt_all[a];
      rd_data[p*DATA_W +: DATA_W] = byp ? wr_data : view[a];
      // a bypassing write retires one outstanding allocation this cycle
      rd_pending[p] = (a != '0) && (byp ? (c > CNT_W'(1)) : (c != '0));
`ifdef REGFILE_PARITY_EN
      rd_perr[p] = (a != '0) && !byp && ((^view[a]) != par_all[a]);
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb (default parameters, two read ports).
// Parity checks are compiled only with REGFILE_PARITY_EN.
module tb_regfile_mp_sb;
  import regfile_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          alloc_en;
  logic [AW-1:0] alloc_addr;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0]    rd_pending;
  logic          err_ovf;
  logic          err_unalloc;
`ifdef REGFILE_PARITY_EN
  logic [1:0]    rd_perr;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_mp_sb dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_pending  (rd_pending),
    .err_ovf     (err_ovf),
    .err_unalloc (err_unalloc)
`ifdef REGFILE_PARITY_EN
    ,
    .rd_perr     (rd_perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    alloc_en = 1'b0;
  endtask

  function automatic err_code_e flag_code(input logic ovf, input logic ua);
    if (ua)  return ERR_UNALLOC;
    if (ovf) return ERR_OVF;
    return ERR_NONE;
  endfunction

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; rd_addr = '0;

    // reset pulse mid-cycle, outputs valid while held
    #12 reset = 1'b0;
    rd_addr[0 +: AW] = 5'd1;
    #1 chk("rst_during_rd1", rd_data[31:0], 32'h1000_0000);
    #5 reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_addr[0 +: AW] = AW'(i);
      #1;
      chk($sformatf("rst_rd%0d", i), rd_data[31:0], (i == 0 || i == 4) ? 32'h0 : 32'h1000_0000);
      chk($sformatf("rst_pend%0d", i), {31'b0, rd_pending[0]}, 32'h0);
    end
    chk("rst_flags", {30'b0, err_ovf, err_unalloc}, 32'h0);

    // allocate 5: not pending in the alloc cycle, pending the next
    cyc();
    alloc_en = 1'b1; alloc_addr = 5'd5; rd_addr[0 +: AW] = 5'd5;
    #2 chk("alloc5_same_pend", {31'b0, rd_pending[0]}, 32'h0);
    cyc(); idle();
    #2 chk("alloc5_next_pend", {31'b0, rd_pending[0]}, 32'h1);

    // write 5 with same-cycle read: bypass data, pending cleared
    cyc();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    rd_addr[AW +: AW] = 5'd6;
    #2 chk("byp5_data", rd_data[31:0], 32'hDEAD_BEEF);
    chk("byp5_pend", {31'b0, rd_pending[0]}, 32'h0);
    chk("byp5_port1", rd_data[63:32], 32'h1000_0000);
    cyc(); idle();
    #2 chk("wr5_stored", rd_data[31:0], 32'hDEAD_BEEF);
    chk("wr5_pend", {31'b0, rd_pending[0]}, 32'h0);

    // write to index 0 is dropped
    cyc();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
    rd_addr[0 +: AW] = 5'd0; rd_addr[AW +: AW] = 5'd0;
    #2 chk("wr0_byp_rd", rd_data[31:0], 32'h0);
    chk("wr0_pend", {30'b0, rd_pending}, 32'h0);
    cyc(); idle();
    #2 chk("wr0_rd", rd_data[63:32], 32'h0);
    chk("wr0_flags", {30'b0, err_ovf, err_unalloc}, 32'h0);

    // scoreboard: two allocations to 7, retired one per write
    alloc_en = 1'b1; alloc_addr = 5'd7;
    cyc();
    cyc(); idle();
    rd_addr[0 +: AW] = 5'd7; rd_addr[AW +: AW] = 5'd7;
    #2 chk("sb7_pend2", {30'b0, rd_pending}, 32'h3);
    cyc();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_000A;
    #2 chk("sb7_w1_pend", {31'b0, rd_pending[0]}, 32'h1);
    chk("sb7_w1_data", rd_data[31:0], 32'h0000_000A);
    cyc();
    wr_data = 32'h0000_000B;
    #2 chk("sb7_w2_pend", {30'b0, rd_pending}, 32'h0);
    chk("sb7_w2_data", rd_data[63:32], 32'h0000_000B);
    cyc(); idle();
    #2 chk("sb7_idle_pend", {31'b0, rd_pending[1]}, 32'h0);
    chk("sb7_idle_data", rd_data[31:0], 32'h0000_000B);

    // simultaneous alloc + write to 9 with one outstanding
    alloc_en = 1'b1; alloc_addr = 5'd9; rd_addr[0 +: AW] = 5'd9;
    cyc();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0099;
    #2 chk("sim9_same_pend", {31'b0, rd_pending[0]}, 32'h0);
    chk("sim9_same_data", rd_data[31:0], 32'h0000_0099);
    cyc(); idle();
    #2 chk("sim9_next_pend", {31'b0, rd_pending[0]}, 32'h1);
    chk("sim9_next_data", rd_data[31:0], 32'h0000_0099);
    chk("sim9_flags", {30'b0, err_ovf, err_unalloc}, 32'h0);

    // overflow: four allocations to 3 with MAX_OUT=3
    alloc_en = 1'b1; alloc_addr = 5'd3; rd_addr[0 +: AW] = 5'd3;
    cyc(); cyc(); cyc();
    #2 chk("ovf3_before", {31'b0, err_ovf}, 32'h0);
    cyc(); idle();
    #2 chk("ovf3_set", {31'b0, err_ovf}, 32'h1);
    // count must be exactly 3: pending until the third write
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0031;
    #2 chk("ovf3_w1_pend", {31'b0, rd_pending[0]}, 32'h1);
    cyc();
    wr_data = 32'h0000_0032;
    #2 chk("ovf3_w2_pend", {31'b0, rd_pending[0]}, 32'h1);
    cyc();
    wr_data = 32'h0000_0033;
    #2 chk("ovf3_w3_pend", {31'b0, rd_pending[0]}, 32'h0);
    cyc(); idle();
    #2 chk("ovf3_drained", {31'b0, rd_pending[0]}, 32'h0);
    chk("ovf3_data", rd_data[31:0], 32'h0000_0033);
    chk("ovf3_no_unalloc", {31'b0, err_unalloc}, 32'h0);
    chk("ovf3_code", 32'(flag_code(err_ovf, err_unalloc)), 32'(ERR_OVF));

    // unallocated write to 12 still lands
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h00C0_FFEE; rd_addr[0 +: AW] = 5'd12;
    #2 chk("ua12_byp", rd_data[31:0], 32'h00C0_FFEE);
    chk("ua12_pend", {31'b0, rd_pending[0]}, 32'h0);
    cyc(); idle();
    #2 chk("ua12_flag", {31'b0, err_unalloc}, 32'h1);
    chk("ua12_data", rd_data[31:0], 32'h00C0_FFEE);
    chk("ua12_code", 32'(flag_code(err_ovf, err_unalloc)), 32'(ERR_UNALLOC));
    cyc(); cyc();
    #2 chk("sticky_flags", {30'b0, err_ovf, err_unalloc}, 32'h3);

`ifdef REGFILE_PARITY_EN
    // corrupt the stored parity of entry 6 (reset value, never written)
    rd_addr[0 +: AW] = 5'd6; rd_addr[AW +: AW] = 5'd5;
    force dut.par_q[6] = 1'b0;
    #2 chk("perr6_port0", {31'b0, rd_perr[0]}, 32'h1);
    chk("perr6_port1", {31'b0, rd_perr[1]}, 32'h0);
    release dut.par_q[6];
`endif

    // final async reset clears flags, counters and data
    cyc();
    #2 reset = 1'b0;
    rd_addr[0 +: AW] = 5'd5; rd_addr[AW +: AW] = 5'd9;
    #1 chk("rst2_flags", {30'b0, err_ovf, err_unalloc}, 32'h0);
    chk("rst2_rd5", rd_data[31:0], 32'h1000_0000);
    chk("rst2_pend9", {31'b0, rd_pending[1]}, 32'h0);
    #2 reset = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-read-port register file with a per-register pending-write scoreboard, for the pipelined CPU datapath.
- It is the next generation of the single-write, two-read, fixed-32x32 register file.
- Adds configurable width, depth and read-port count, same-cycle write-to-read bypass, and outstanding-write tracking so decode can stall on RAW hazards.
- Sits between decode (reads, destination allocation) and writeback (writes).

Parameters:
- DATA_W, 32, data width in bits.
- DEPTH, 32, number of registers; entry 0 is hardwired zero; must be a power of 2, at least 4.
- NUM_RD, 2, number of combinational read ports (1..4).
- MAX_OUT, 3, maximum outstanding allocations per register (1..7).
- RESET_VAL, 32'h10000000, reset value of entries 1..DEPTH-1.
- ZERO_IDX, 4, one entry that resets to 0 instead of RESET_VAL; ZERO_IDX=0 disables this.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  writeback write strobe.
- wr_addr  in  AW  write index, where AW=$clog2(DEPTH).
- wr_data  in  DATA_W  write data.
- alloc_en  in  1  decode issues an instruction that will write alloc_addr.
- alloc_addr  in  AW  destination index being allocated.
- rd_addr  in  NUM_RD*AW  packed read indices; port i is at [i*AW +: AW].
- rd_data  out  NUM_RD*DW  packed read data.
- rd_pending  out  NUM_RD  port i's register has an unresolved outstanding write.
- err_ovf  out  1  sticky: alloc attempted with counter already at MAX_OUT.
- err_unalloc  out  1  sticky: write to a register whose counter is 0 (index != 0).

Behaviour:
- Storage is flops for entries 1..DEPTH-1. No storage exists for entry 0.
- Reset (reset==0, asynchronous, no clk needed):
  - entries take RESET_VAL, except entry ZERO_IDX which takes 0;
  - all pending counters go to 0; err_ovf=0, err_unalloc=0.
  - Outputs stay valid and combinational during reset.
- Write: at posedge clk, if wr_en and wr_addr!=0, entry[wr_addr] takes wr_data. Writes to index 0 are dropped silently and do not touch scoreboard or flags.
- Read (per port i, combinational, zero latency):
  - rd_addr==0 returns 0;
  - else if wr_en and wr_addr==rd_addr, returns wr_data (write-first bypass);
  - else returns the stored entry.
- Scoreboard: per entry 1..DEPTH-1, a counter cnt of width $clog2(MAX_OUT+1). At posedge:
  - inc = alloc_en and alloc_addr!=0; dec = wr_en and wr_addr!=0.
  - Same index with inc and dec both set: cnt unchanged.
  - inc only: if cnt==MAX_OUT, cnt is held and err_ovf is set; else cnt+1.
  - dec only: if cnt==0, cnt stays 0, the write still lands, and err_unalloc is set; else cnt-1.
  - Different indices: each is updated independently.
- rd_pending[i] = (rd_addr!=0) and (effective count != 0).
  - Effective count is cnt[rd_addr] minus 1 if a same-cycle bypassing write hits that index.
  - So cnt==1 plus a same-cycle write gives pending=0 and the bypass data is valid.
  - Same-cycle alloc does not raise rd_pending that cycle; it takes effect next cycle.
- Error flags are sticky until reset. No other clear exists.

Optional Feature:
- Macro REGFILE_PARITY_EN.
- Defined:
  - each entry stores one extra even-parity bit, computed at write time and at reset;
  - adds output rd_perr[NUM_RD];
  - rd_perr[i] = recomputed parity of the stored entry != stored bit;
  - rd_perr is forced to 0 for index 0 and on the bypass path.
- Undefined: no parity storage, and port rd_perr is absent.

Decomposition:
- Shared package regfile_pkg holds:
  - localparam functions for AW and CNT_W;
  - error-code enum {ERR_NONE, ERR_OVF, ERR_UNALLOC} used by the bench;
  - the default RESET_VAL constant.
- One natural sub-module: regfile_sb_cnt, a single saturating up/down counter with inc, dec, max, ovf and unalloc pulses. It is instantiated DEPTH-1 times via generate.

Test Plan:
- Reset: pulse reset low mid-cycle, then read all indices on port 0 → 0x10000000 everywhere except idx4=0 and idx0=0; all rd_pending=0; flags 0.
- Write/bypass: wr_en, addr 5, data 0xDEADBEEF, with rd_addr0=5 the same cycle → rd_data0=0xDEADBEEF that cycle and the next. A write to addr 0 leaves a read of 0 returning 0.
- Scoreboard: alloc 7 twice, then read 7 → pending=1. One write to 7 → pending stays 1. Second write cycle → pending=0 in that same cycle (bypass).
- Simultaneous: alloc 9 and write 9 in the same cycle with cnt=1 → cnt stays 1, pending=1 the next cycle, data updated.
- Errors: alloc 3 MAX_OUT+1 times → err_ovf=1 and cnt=3. Write idx 12 with cnt=0 → err_unalloc=1 and data written. Both flags hold until reset.
- Parity (REGFILE_PARITY_EN): force-flip the stored bit 0 of entry 6 → rd_perr for a port reading 6 =1; other ports =0.
